spi_master_tx: RTL

//  SPI master (initiator) that drives pad_cs/pad_sck/pad_dout into the on-chip SPI slave shift register.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_master_tx_if.sv | 18 +
 rtl/spi_clk_div.sv | 30 +++
 rtl/spi_master_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width agreed with the on-chip slave and master FSM states.
package spi_pkg;

    localparam int unsigned SPI_FRAME_W = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_mst_state_t;

endpackage

// File: rtl/spi_master_tx_if.sv
// System-side valid/ready bus into the SPI master: transmit word in, reply word and status out.
interface spi_master_tx_if
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = SPI_FRAME_W
) ();

    logic               tx_valid;
    logic               tx_ready;
    logic [FRAME_W-1:0] tx_data;
    logic               rx_valid;
    logic [FRAME_W-1:0] rx_data;
    logic               busy;

    modport master (output tx_valid, tx_data, input tx_ready, rx_valid, rx_data, busy);
    modport slave  (input tx_valid, tx_data, output tx_ready, rx_valid, rx_data, busy);

endinterface

// File: rtl/spi_clk_div.sv
// SCK half-period timer: one-cycle half_tick_c every CLK_DIV cycles while enabled.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic half_tick_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt;

    assign half_tick_c = en && (cnt == CNT_W'(CLK_DIV - 1));

    // Restarting from zero on enable keeps every phase exactly CLK_DIV long.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en || half_tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// Mode-0, MSB-first SPI master: serialises one frame per accepted word and returns the slave's reply.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = SPI_FRAME_W,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    spi_master_tx_if.slave   bus,
    output logic             pad_cs,
    output logic             pad_sck,
    output logic             pad_dout,
    input  logic             pad_din
);

    localparam int unsigned EDGE_W    = $clog2(2 * FRAME_W + 1);
    localparam int unsigned GAP_W     = $clog2(CS_GAP + 1);
    localparam int unsigned LAST_EDGE = 2 * FRAME_W - 1;

    spi_mst_state_t     state, state_nxt;
    logic [FRAME_W-1:0] tx_sr, tx_sr_nxt;
    logic [FRAME_W-1:0] rx_sr, rx_sr_nxt;
    logic [EDGE_W-1:0]  edge_cnt, edge_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               cs_nxt, sck_nxt;
    logic               tx_ready, ready_nxt;
    logic               rx_valid, rxv_nxt;
    logic [FRAME_W-1:0] rx_data, rxd_nxt;
    logic               busy, busy_nxt;
    logic               div_en, half_tick_c;

    assign div_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (div_en),
        .half_tick_c (half_tick_c)
    );

    // MOSI is the MSB flop of the transmit shifter.
    assign pad_dout     = tx_sr[FRAME_W-1];
    assign bus.tx_ready = tx_ready;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_data  = rx_data;
    assign bus.busy     = busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            gap_cnt  <= '0;
            pad_cs   <= 1'b1;
            pad_sck  <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_sr    <= tx_sr_nxt;
            rx_sr    <= rx_sr_nxt;
            edge_cnt <= edge_nxt;
            gap_cnt  <= gap_nxt;
            pad_cs   <= cs_nxt;
            pad_sck  <= sck_nxt;
            tx_ready <= ready_nxt;
            rx_valid <= rxv_nxt;
            rx_data  <= rxd_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_sr_nxt = tx_sr;
        rx_sr_nxt = rx_sr;
        edge_nxt  = edge_cnt;
        gap_nxt   = gap_cnt;
        cs_nxt    = pad_cs;
        sck_nxt   = pad_sck;
        ready_nxt = tx_ready;
        rxv_nxt   = 1'b0;
        rxd_nxt   = rx_data;

        unique case (state)
            IDLE: begin
                cs_nxt    = 1'b1;
                sck_nxt   = 1'b0;
                ready_nxt = 1'b1;
                if (bus.tx_valid && tx_ready) begin
                    state_nxt = SETUP;
                    tx_sr_nxt = bus.tx_data;
                    cs_nxt    = 1'b0;
                    ready_nxt = 1'b0;
                end
            end
            SETUP: begin
                if (half_tick_c) begin
                    state_nxt = SHIFT;
                    edge_nxt  = '0;
                end
            end
            SHIFT: begin
                // Even edges rise and sample MISO; odd edges fall and advance MOSI.
                if (half_tick_c) begin
                    edge_nxt = edge_cnt + EDGE_W'(1);
                    if (!pad_sck) begin
                        sck_nxt   = 1'b1;
                        rx_sr_nxt = {rx_sr[FRAME_W-2:0], pad_din};
                    end else begin
                        sck_nxt = 1'b0;
                        if (edge_cnt == EDGE_W'(LAST_EDGE)) begin
                            state_nxt = HOLD;
                        end else begin
                            tx_sr_nxt = {tx_sr[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (half_tick_c) begin
                    state_nxt = GAP;
                    cs_nxt    = 1'b1;
                    tx_sr_nxt = '0;
                    rxv_nxt   = 1'b1;
                    rxd_nxt   = rx_sr;
                    gap_nxt   = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
